// File: rtl/time_keeper_pkg.sv
// Shared BCD limits and the legality check used by the time-load path.
package time_keeper_pkg;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    // A legal value has two decimal digits and does not exceed max.
    // With both digits decimal, a plain binary compare orders BCD correctly.
    function automatic logic bcd_legal(input logic [7:0] value, input logic [7:0] max);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
    endfunction

endpackage

// File: rtl/time_keeper_counter.sv
// Two-digit BCD modulo counter: wraps MAX -> 00; load takes priority over inc.
module bcd_mod_counter #(
    parameter logic [7:0] MAX     = 8'h59,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] q,
    output logic       wrap
);

    function automatic logic [7:0] bcd_next(input logic [7:0] v);
        logic [7:0] r;
        if (v == MAX)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    assign wrap = inc && (q == MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RST_VAL;
        else if (load)
            q <= load_val;
        else if (inc)
            q <= bcd_next(q);
    end

endmodule

// File: rtl/time_keeper.sv
// 24 h BCD wall clock driven by a 1 Hz strobe, with validated load and manual adjust.
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter logic [7:0] RST_HH = 8'h00,
    parameter logic [7:0] RST_MM = 8'h00,
    parameter logic [7:0] RST_SS = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_pulse,
    input  logic       run,
    input  logic       set_valid,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    input  logic       adj_min,
    input  logic       adj_hour,
    output logic       set_ack,
    output logic       set_err,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       min_tick,
    output logic       hour_tick,
    output logic       day_tick
);

    logic set_legal;
    logic load_en;
    logic adj_en;
    logic tick;
    logic ss_inc, mm_inc, hh_inc;
    logic ss_wrap, mm_wrap, hh_wrap;

    // Priority: load request > adjust > running second tick; losers are dropped.
    always_comb begin
        set_legal = bcd_legal(set_hh, HOUR_MAX) && bcd_legal(set_mm, MIN_MAX)
                    && bcd_legal(set_ss, SEC_MAX);
        load_en   = set_valid && set_legal;
        adj_en    = !set_valid && (adj_min || adj_hour);
        tick      = !set_valid && !(adj_min || adj_hour) && sec_pulse && run;
        ss_inc    = tick;
        mm_inc    = (tick && ss_wrap) || (adj_en && adj_min);
        hh_inc    = (tick && ss_wrap && mm_wrap) || (adj_en && adj_hour);
    end

    bcd_mod_counter #(.MAX(SEC_MAX), .RST_VAL(RST_SS)) u_ss (
        .clk(clk), .rst(rst), .inc(ss_inc), .load(load_en), .load_val(set_ss),
        .q(ss), .wrap(ss_wrap)
    );

    bcd_mod_counter #(.MAX(MIN_MAX), .RST_VAL(RST_MM)) u_mm (
        .clk(clk), .rst(rst), .inc(mm_inc), .load(load_en), .load_val(set_mm),
        .q(mm), .wrap(mm_wrap)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX), .RST_VAL(RST_HH)) u_hh (
        .clk(clk), .rst(rst), .inc(hh_inc), .load(load_en), .load_val(set_hh),
        .q(hh), .wrap(hh_wrap)
    );

    // Pulse outputs are registered so they line up with the updated time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_ack   <= 1'b0;
            set_err   <= 1'b0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
        end else begin
            set_ack   <= load_en;
            set_err   <= set_valid && !set_legal;
            min_tick  <= tick && ss_wrap;
            hour_tick <= tick && ss_wrap && mm_wrap;
            day_tick  <= tick && ss_wrap && mm_wrap && hh_wrap;
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed scenarios plus random stimulus against a seconds-of-day model.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sec_pulse = 1'b0, run = 1'b0, set_valid = 1'b0;
    logic [7:0] set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;
    logic       adj_min = 1'b0, adj_hour = 1'b0;
    logic       set_ack, set_err, min_tick, hour_tick, day_tick;
    logic [7:0] hh, mm, ss;

    int checks = 0;
    int errors = 0;

    // reference model state (plain binary)
    int  m_h, m_m, m_s;
    bit  e_ack, e_err, e_mt, e_ht, e_dt;

    time_keeper #(.RST_HH(8'h12), .RST_MM(8'h00), .RST_SS(8'h00)) dut (
        .clk(clk), .rst(rst), .sec_pulse(sec_pulse), .run(run),
        .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .adj_min(adj_min), .adj_hour(adj_hour),
        .set_ack(set_ack), .set_err(set_err),
        .hh(hh), .mm(mm), .ss(ss),
        .min_tick(min_tick), .hour_tick(hour_tick), .day_tick(day_tick)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int from_bcd(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit legal(input logic [7:0] v, input int max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (from_bcd(v) <= max);
    endfunction

    task automatic model_reset();
        m_h = 12; m_m = 0; m_s = 0;
        {e_ack, e_err, e_mt, e_ht, e_dt} = '0;
    endtask

    task automatic model_step();
        int sod;
        {e_ack, e_err, e_mt, e_ht, e_dt} = '0;
        if (set_valid) begin
            if (legal(set_hh, 23) && legal(set_mm, 59) && legal(set_ss, 59)) begin
                m_h = from_bcd(set_hh); m_m = from_bcd(set_mm); m_s = from_bcd(set_ss);
                e_ack = 1'b1;
            end else begin
                e_err = 1'b1;
            end
        end else if (adj_min || adj_hour) begin
            if (adj_min)  m_m = (m_m + 1) % 60;
            if (adj_hour) m_h = (m_h + 1) % 24;
        end else if (sec_pulse && run) begin
            e_mt = (m_s == 59);
            e_ht = e_mt && (m_m == 59);
            e_dt = e_ht && (m_h == 23);
            sod  = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h  = sod / 3600;
            m_m  = (sod / 60) % 60;
            m_s  = sod % 60;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_hh"}, hh, to_bcd(m_h));
        check({tag, "_mm"}, mm, to_bcd(m_m));
        check({tag, "_ss"}, ss, to_bcd(m_s));
        check({tag, "_pulses"}, {set_ack, set_err, min_tick, hour_tick, day_tick},
              {e_ack, e_err, e_mt, e_ht, e_dt});
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge,
    // then one-cycle pulse inputs are cleared.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(tag);
        sec_pulse = 1'b0; set_valid = 1'b0; adj_min = 1'b0; adj_hour = 1'b0;
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                        input string tag);
        set_valid = 1'b1; set_hh = h; set_mm = m; set_ss = s;
        cyc(tag);
    endtask

    initial begin
        // 1: reset value and quiet release
        rst = 1'b1;
        #15;
        model_reset();
        compare_all("rst");
        @(negedge clk);
        rst = 1'b0;
        cyc("rel0");
        cyc("rel1");
        check("rst_hh_const", hh, 8'h12);

        // 2: full-day rollover
        run = 1'b1;
        load(8'h23, 8'h59, 8'h58, "t2_load");
        sec_pulse = 1'b1; cyc("t2_s1");
        check("t2_ss59", ss, 8'h59);
        repeat (3) cyc("t2_idle");
        sec_pulse = 1'b1; cyc("t2_s2");
        check("t2_all_ticks", {hh, mm, ss, min_tick, hour_tick, day_tick}, {24'h000000, 3'b111});
        cyc("t2_after");
        check("t2_ticks_gone", {min_tick, hour_tick, day_tick}, 3'b000);

        // 3: load validation
        load(8'h12, 8'h34, 8'h56, "t3_base");
        load(8'h01, 8'h60, 8'h00, "t3_mm60");
        check("t3_err_mm", {set_err, set_ack, hh, mm, ss}, {2'b10, 24'h123456});
        load(8'h01, 8'h02, 8'h1A, "t3_ss1a");
        check("t3_err_ss", {set_err, set_ack}, 2'b10);
        load(8'h01, 8'h02, 8'h09, "t3_ok");
        check("t3_ack", {set_err, set_ack, hh, mm, ss}, {2'b01, 24'h010209});

        // 4: load wins over a simultaneous tick
        load(8'h10, 8'h00, 8'h00, "t4_base");
        sec_pulse = 1'b1;
        load(8'h05, 8'h05, 8'h05, "t4_race");
        check("t4_time", {hh, mm, ss, set_ack, min_tick}, {24'h050505, 2'b10});

        // 5: frozen time, adjust wraps without carries or ticks
        run = 1'b0;
        repeat (5) begin
            sec_pulse = 1'b1; cyc("t5_frozen");
        end
        check("t5_frozen_time", {hh, mm, ss}, 24'h050505);
        load(8'h10, 8'h59, 8'h30, "t5_ld1");
        adj_min = 1'b1; cyc("t5_adjm");
        check("t5_adjm_val", {hh, mm, ss, hour_tick}, {24'h100030, 1'b0});
        load(8'h23, 8'h10, 8'h00, "t5_ld2");
        adj_hour = 1'b1; cyc("t5_adjh");
        check("t5_adjh_val", {hh, mm, day_tick}, {16'h0010, 1'b0});
        adj_hour = 1'b1; adj_min = 1'b1; cyc("t5_both");

        // 6: asynchronous reset mid-count
        run = 1'b1;
        load(8'h07, 8'h30, 8'h14, "t6_load");
        sec_pulse = 1'b1; cyc("t6_tick");
        check("t6_pre", {hh, mm, ss}, 24'h073015);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("t6_async", {hh, mm, ss, set_ack, set_err, min_tick, hour_tick, day_tick},
              {24'h120000, 5'b00000});
        @(negedge clk);
        rst = 1'b0;
        cyc("t6_rel");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) run = ~run;
            else if ($urandom_range(0, 9) == 0) run = 1'b1;
            sec_pulse = ($urandom_range(0, 2) == 0);
            set_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 0) begin
                set_hh = to_bcd(int'($urandom_range(0, 23)));
                set_mm = to_bcd(int'($urandom_range(0, 59)));
                set_ss = to_bcd(int'($urandom_range(50, 59)));
            end else begin
                set_hh = 8'($urandom);
                set_mm = 8'($urandom);
                set_ss = 8'($urandom);
            end
            adj_min  = ($urandom_range(0, 11) == 0);
            adj_hour = ($urandom_range(0, 15) == 0);
            cyc("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
